// File: rtl/mux_scan.sv
// mux_scan: N-channel W-bit registered mux with manual select and auto-scan.
// Ports: i_clk, i_rst_n (async low), i_data (packed channels), i_sel,
//   i_mode (0 manual / 1 scan), i_hold (scan freeze), i_mask (MUX_MASK_EN only),
//   o_data, o_ch, o_switch (one-cycle pulse on o_ch change). Macro: MUX_MASK_EN.
module mux_scan #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  parameter  int DWELL = 1000,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_CH*W-1:0] i_data,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_mode,
  input  logic              i_hold,
`ifdef MUX_MASK_EN
  input  logic [N_CH-1:0]   i_mask,
`endif
  output logic [W-1:0]      o_data,
  output logic [SEL_W-1:0]  o_ch,
  output logic              o_switch
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DWELL - 1);
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(N_CH);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [SEL_W-1:0] ch_next;
  logic [SEL_W-1:0] ch_step;
  logic [N_CH-1:0]  en;
  logic             sel_ok;
  logic             found;
  int               idx;
  logic [W-1:0]     chans [N_CH];

`ifdef MUX_MASK_EN
  assign en = i_mask;
`else
  assign en = '1;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign chans[k] = i_data[k*W +: W];
  end

  assign sel_ok = {1'b0, i_sel} < NCH;

  // Next enabled channel after o_ch, ascending with wrap.
  // Nothing else enabled leaves the channel where it is.
  always_comb begin
    ch_step = o_ch;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k < N_CH; k++) begin
      idx = int'(o_ch) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && en[idx[SEL_W-1:0]]) begin
        ch_step = idx[SEL_W-1:0];
        found   = 1'b1;
      end
    end
  end

  // Entering scan keeps the channel and restarts the dwell count.
  always_comb begin
    ch_next  = o_ch;
    cnt_next = '0;
    if (!i_mode) begin
      if (sel_ok) ch_next = i_sel;
    end else if (state == SCAN) begin
      cnt_next = cnt;
      if (!i_hold) begin
        if (cnt == CMAX) begin
          cnt_next = '0;
          ch_next  = ch_step;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= MANUAL;
      cnt      <= '0;
      o_ch     <= '0;
      o_data   <= '0;
      o_switch <= 1'b0;
    end else begin
      state    <= i_mode ? SCAN : MANUAL;
      cnt      <= cnt_next;
      o_ch     <= ch_next;
      o_data   <= chans[ch_next];
      o_switch <= (ch_next != o_ch);
    end
  end

endmodule
